// File: rtl/stream_sequencer.sv
// stream_sequencer
// Job controller for the stream datapath (MIF -> DDS/aligners -> 4x4 array -> OSF).
// Each job goes through unit clear, MIF load, array compute and OSF drain, and
// then returns to an automatic clear. MIF writes and OSF reads are gated from
// the decoded AHB data-phase requests. Offending requests produce a one-cycle
// err pulse.
//
// Ports:
//   HCLK        in   system clock, rising edge
//   HRESET      in   synchronous active-high reset
//   wr_req      in   decoded AHB write data phase
//   rd_req      in   decoded AHB read request
//   mif_full    in   MIF full status
//   osf_empty   in   OSF empty status
//   valid       in   array result-valid strobe
//   mif_we      out  MIF write enable (combinational)
//   osf_re      out  OSF read enable (combinational)
//   ip_resetn   out  active-low reset to DDS/array/MIF
//   acc_resetn  out  active-low accumulator clear
//   busy        out  stall request to the wrapper (HREADYOUT low)
//   err         out  one-cycle error pulse, registered
//   state       out  CLEAR=0, IDLE=1, LOAD=2, COMPUTE=3, DRAIN=4
//   result_cnt  out  results captured in the current job
//   timeout     out  sticky compute-abort flag
module stream_sequencer #(
  parameter int LOAD_WORDS = 8,
  parameter int OSF_DEPTH  = 8,
  parameter int CLR_CYCLES = 4,
  parameter int TIMEOUT    = 256,
  parameter int CNT_W      = 4
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic             mif_full,
  input  logic             osf_empty,
  input  logic             valid,
  output logic             mif_we,
  output logic             osf_re,
  output logic             ip_resetn,
  output logic             acc_resetn,
  output logic             busy,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] result_cnt,
  output logic             timeout
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CLR_W-1:0] CLR_LAST  = CLR_W'(CLR_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_WORDS);
  localparam logic [CNT_W-1:0] OSF_MAX   = CNT_W'(OSF_DEPTH);

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_IDLE    = 3'd1,
    S_LOAD    = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CLR_W-1:0] r_clr_cnt;
  logic [CNT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0] r_result_cnt;
  logic [CNT_W-1:0] r_drain_cnt;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_timeout;
  logic             r_err;
  logic             r_valid_q;

  logic             w_both;
  logic             w_fall;
  logic [CNT_W-1:0] w_load_next;
  logic [CNT_W-1:0] w_drain_next;

  // A simultaneous write and read is rejected outright, so both enables
  // are masked by w_both.
  assign w_both       = wr_req & rd_req;
  assign w_fall       = r_valid_q & ~valid & (r_result_cnt != '0);
  assign w_load_next  = r_load_cnt + 1'b1;
  assign w_drain_next = r_drain_cnt + 1'b1;

  assign mif_we = wr_req & ~w_both &
                  ((r_state == S_IDLE) | ((r_state == S_LOAD) & ~mif_full));
  assign osf_re = rd_req & ~w_both & (r_state == S_DRAIN) & ~osf_empty;

  assign busy       = (r_state == S_CLEAR) | (r_state == S_COMPUTE);
  assign ip_resetn  = (r_state != S_CLEAR);
  assign acc_resetn = (r_state != S_CLEAR);
  assign err        = r_err;
  assign state      = r_state;
  assign result_cnt = r_result_cnt;
  assign timeout    = r_timeout;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state      <= S_CLEAR;
      r_clr_cnt    <= '0;
      r_load_cnt   <= '0;
      r_result_cnt <= '0;
      r_drain_cnt  <= '0;
      r_wd_cnt     <= '0;
      r_timeout    <= 1'b0;
      r_err        <= 1'b0;
      r_valid_q    <= 1'b0;
    end else begin
      r_valid_q <= valid;
      r_err     <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          // Requests here are stalled by busy: no accept, no error.
          if (r_clr_cnt == CLR_LAST) begin
            r_state      <= S_IDLE;
            r_clr_cnt    <= '0;
            r_load_cnt   <= '0;
            r_result_cnt <= '0;
            r_drain_cnt  <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (w_both) begin
            r_err <= 1'b1;
          end else if (wr_req) begin
            r_load_cnt <= CNT_W'(1);
            r_wd_cnt   <= '0;
            if (LOAD_WORDS == 1) r_state <= S_COMPUTE;
            else                 r_state <= S_LOAD;
          end else if (rd_req) begin
            r_err <= 1'b1;  // nothing to read yet
          end
        end
        S_LOAD: begin
          if (w_both) begin
            r_err <= 1'b1;
          end else if (wr_req) begin
            if (mif_full) begin
              r_err <= 1'b1;
            end else begin
              r_load_cnt <= w_load_next;
              if (w_load_next == LOAD_LAST) begin
                r_state  <= S_COMPUTE;
                r_wd_cnt <= '0;
              end
            end
          end else if (rd_req) begin
            r_err <= 1'b1;
          end
        end
        S_COMPUTE: begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          if (valid && (r_result_cnt != OSF_MAX))
            r_result_cnt <= r_result_cnt + 1'b1;
          // End of the result burst wins over a coincident watchdog expiry.
          if (w_fall) begin
            r_state <= S_DRAIN;
          end else if (r_wd_cnt == WD_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (w_both) begin
            r_err <= 1'b1;
          end else if (rd_req) begin
            if (osf_empty) begin
              // Underflow: the job is unrecoverable, reset the units.
              r_err     <= 1'b1;
              r_state   <= S_CLEAR;
              r_clr_cnt <= '0;
            end else begin
              r_drain_cnt <= w_drain_next;
              if (w_drain_next == r_result_cnt) begin
                r_state   <= S_CLEAR;
                r_clr_cnt <= '0;
              end
            end
          end else if (wr_req) begin
            r_err <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_CLEAR;
          r_clr_cnt <= '0;
        end
      endcase
    end
  end

endmodule
